// File: rtl/parking_occupancy_counter.sv
// Parking-lot occupancy counter: edge-detects Enter/Exit levels, tracks 0..CAPACITY with BCD and 7-seg outputs.
// Optional peak-occupancy register enabled by defining OCC_PEAK_EN.
module parking_occupancy_counter #(
    parameter int CAPACITY = 25,
    parameter int CNT_W    = 7
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enter,
    input  logic             Exit,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       ones_bcd,
    output logic [3:0]       tens_bcd,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic             full,
    output logic             empty,
    output logic             err,
    output logic [CNT_W-1:0] peak
);

    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    logic             r_enter_q, r_exit_q;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_ones, r_tens;
    logic [6:0]       r_hex0, r_hex1;
    logic             r_full, r_empty, r_err;

    logic             w_enter_p, w_exit_p;
    logic             w_inc, w_dec, w_illegal;
    logic [CNT_W-1:0] w_next_count;
    logic [3:0]       w_next_ones, w_next_tens;

    assign w_enter_p = Enter & ~r_enter_q;
    assign w_exit_p  = Exit  & ~r_exit_q;

    // Simultaneous enter and exit cancel out and are never an error.
    assign w_inc     = w_enter_p & ~w_exit_p & (r_count != CAP_C);
    assign w_dec     = w_exit_p  & ~w_enter_p & (r_count != '0);
    assign w_illegal = (w_enter_p & ~w_exit_p & (r_count == CAP_C))
                     | (w_exit_p  & ~w_enter_p & (r_count == '0));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_count = r_count;
        w_next_ones  = r_ones;
        w_next_tens  = r_tens;
        if (w_inc) begin
            w_next_count = r_count + CNT_W'(1);
            if (r_ones == 4'd9) begin
                w_next_ones = 4'd0;
                w_next_tens = r_tens + 4'd1;
            end else begin
                w_next_ones = r_ones + 4'd1;
            end
        end else if (w_dec) begin
            w_next_count = r_count - CNT_W'(1);
            if (r_ones == 4'd0) begin
                w_next_ones = 4'd9;
                w_next_tens = r_tens - 4'd1;
            end else begin
                w_next_ones = r_ones - 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // Edge-detect history set high so a level held through reset is not counted.
            r_enter_q <= 1'b1;
            r_exit_q  <= 1'b1;
            r_count   <= '0;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_hex0    <= 7'b1000000;
            r_hex1    <= SEG_BLANK;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_enter_q <= Enter;
            r_exit_q  <= Exit;
            r_count   <= w_next_count;
            r_ones    <= w_next_ones;
            r_tens    <= w_next_tens;
            r_hex0    <= seg7(w_next_ones);
            r_hex1    <= (w_next_tens == 4'd0) ? SEG_BLANK : seg7(w_next_tens);
            r_full    <= (w_next_count == CAP_C);
            r_empty   <= (w_next_count == '0);
            r_err     <= r_err | w_illegal;
        end
    end

`ifdef OCC_PEAK_EN
    logic [CNT_W-1:0] r_peak;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_peak <= '0;
        end else if (w_next_count > r_peak) begin
            r_peak <= w_next_count;
        end
    end

    assign peak = r_peak;
`else
    assign peak = '0;
`endif

    assign count    = r_count;
    assign ones_bcd = r_ones;
    assign tens_bcd = r_tens;
    assign HEX0     = r_hex0;
    assign HEX1     = r_hex1;
    assign full     = r_full;
    assign empty    = r_empty;
    assign err      = r_err;

endmodule
